// File: rtl/pid_un_pwm.sv
// pid_un_pwm: PWM output stage fed by the PID control word.
// Scales i_un by an arithmetic right shift, saturates the magnitude to PERIOD,
// and applies new duty values only at period boundaries so that a pulse is
// never cut short or stretched. dir carries the sign for an H-bridge.
//
//   state | meaning
//   ------+------------------------------------------------------------
//   IDLE  | i_en low: counter parked at 0, pwm forced low
//   RUN   | counter cycles 0..PERIOD-1, duty compared against counter
module pid_un_pwm #(
  parameter int PERIOD = 1000,
  parameter int CW     = 10,
  parameter int SHIFT  = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [31:0]   i_un,
  input  logic          i_valid,
  input  logic          i_en,
  input  logic          i_clr,
  output logic          pwm,
  output logic          dir,
  output logic [CW-1:0] duty,
  output logic          sat,
  output logic          upd,
  output logic          ovr
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  localparam logic [CW-1:0] CNT_LAST = CW'(PERIOD - 1);
  localparam logic [CW-1:0] DUTY_MAX = CW'(PERIOD);
  localparam logic [32:0]   MAG_MAX  = 33'(PERIOD);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          pwm_q, pwm_d;
  logic          dir_q, dir_d;
  logic [CW-1:0] duty_q, duty_d;
  logic          sat_q, sat_d;
  logic          upd_q, upd_d;
  logic          ovr_q, ovr_d;
  logic          pend_q, pend_d;
  logic [CW-1:0] pend_duty_q, pend_duty_d;
  logic          pend_neg_q, pend_neg_d;
  logic          pend_sat_q, pend_sat_d;

  logic signed [31:0] conv_s;
  logic               conv_neg;
  logic [32:0]        conv_mag;
  logic [CW-1:0]      conv_duty;
  logic               conv_sat;
  logic               boundary;
  logic               apply_new;
  logic               apply_pend;

  // Convert the incoming control word; the 33-bit magnitude keeps -2^31 exact.
  always_comb begin
    conv_s    = $signed(i_un) >>> SHIFT;
    conv_neg  = conv_s[31];
    conv_mag  = conv_neg ? (33'd0 - {conv_s[31], conv_s}) : {1'b0, conv_s};
    conv_sat  = (conv_mag > MAG_MAX);
    conv_duty = conv_sat ? DUTY_MAX : conv_mag[CW-1:0];
  end

  // State and datapath registers, cleared synchronously.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      pwm_q       <= 1'b0;
      dir_q       <= 1'b0;
      duty_q      <= '0;
      sat_q       <= 1'b0;
      upd_q       <= 1'b0;
      ovr_q       <= 1'b0;
      pend_q      <= 1'b0;
      pend_duty_q <= '0;
      pend_neg_q  <= 1'b0;
      pend_sat_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pwm_q       <= pwm_d;
      dir_q       <= dir_d;
      duty_q      <= duty_d;
      sat_q       <= sat_d;
      upd_q       <= upd_d;
      ovr_q       <= ovr_d;
      pend_q      <= pend_d;
      pend_duty_q <= pend_duty_d;
      pend_neg_q  <= pend_neg_d;
      pend_sat_q  <= pend_sat_d;
    end
  end

  // Next state: any cycle with i_en low parks the block in IDLE.
  always_comb begin
    state_d = i_en ? S_RUN : S_IDLE;
  end

  // Counter, pending slot, boundary update and registered PWM compare.
  always_comb begin
    boundary   = (state_q == S_RUN) && i_en && (cnt_q == CNT_LAST);
    apply_new  = boundary && i_valid;
    apply_pend = boundary && !i_valid && pend_q;

    // The first RUN cycle sits at 0, so the counter only advances from RUN.
    if (!i_en || (state_q == S_IDLE)) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end

    duty_d = duty_q;
    dir_d  = dir_q;
    sat_d  = sat_q;
    if (apply_new) begin
      duty_d = conv_duty;
      dir_d  = conv_neg;
      sat_d  = conv_sat;
    end else if (apply_pend) begin
      duty_d = pend_duty_q;
      dir_d  = pend_neg_q;
      sat_d  = pend_sat_q;
    end
    upd_d = apply_new || apply_pend;

    // A boundary always drains the slot: either it was applied, or a fresh
    // sample bypassed it and made it stale.
    pend_d      = pend_q;
    pend_duty_d = pend_duty_q;
    pend_neg_d  = pend_neg_q;
    pend_sat_d  = pend_sat_q;
    if (boundary) begin
      pend_d = 1'b0;
    end else if (i_valid) begin
      pend_d      = 1'b1;
      pend_duty_d = conv_duty;
      pend_neg_d  = conv_neg;
      pend_sat_d  = conv_sat;
    end

    // Set beats clear when both happen in the same cycle.
    if (i_valid && pend_q && !boundary) begin
      ovr_d = 1'b1;
    end else if (i_clr) begin
      ovr_d = 1'b0;
    end else begin
      ovr_d = ovr_q;
    end

    // Compare against the values the next cycle will hold so pwm lines up
    // with the counter and switches duty exactly at cnt = 0.
    pwm_d = i_en && (cnt_d < duty_d);
  end

  // Registered outputs.
  always_comb begin
    pwm  = pwm_q;
    dir  = dir_q;
    duty = duty_q;
    sat  = sat_q;
    upd  = upd_q;
    ovr  = ovr_q;
  end

endmodule

// File: tb/tb_pid_un_pwm.sv
// Testbench for pid_un_pwm with default parameters (PERIOD 1000, SHIFT 8).
// Each applied sample queues its expected {duty, dir, sat}; a monitor pops
// and compares on every upd pulse.
module tb_pid_un_pwm;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] i_un;
  logic        i_valid;
  logic        i_en;
  logic        i_clr;
  logic        pwm;
  logic        dir;
  logic [9:0]  duty;
  logic        sat;
  logic        upd;
  logic        ovr;

  int n_checks = 0;
  int n_fail   = 0;

  int   m_cnt  = 0;
  logic m_idle = 1'b1;

  typedef struct {
    int duty;
    int dir;
    int sat;
  } exp_t;

  exp_t sb[$];

  pid_un_pwm #(.PERIOD(1000), .CW(10), .SHIFT(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .i_un    (i_un),
    .i_valid (i_valid),
    .i_en    (i_en),
    .i_clr   (i_clr),
    .pwm     (pwm),
    .dir     (dir),
    .duty    (duty),
    .sat     (sat),
    .upd     (upd),
    .ovr     (ovr)
  );

  always #5 clk = ~clk;

  // Reference counter position, used only to time stimulus.
  always @(posedge clk) begin
    if (rst || !i_en) begin
      m_cnt  <= 0;
      m_idle <= 1'b1;
    end else if (m_idle) begin
      m_cnt  <= 0;
      m_idle <= 1'b0;
    end else begin
      m_cnt <= (m_cnt == 999) ? 0 : m_cnt + 1;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (!rst && upd === 1'b1) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL upd_unexpected: got upd=1 duty=%0d expected no update", duty);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_duty", int'(duty), e.duty);
        chk("sb_dir",  int'(dir),  e.dir);
        chk("sb_sat",  int'(sat),  e.sat);
      end
    end
  end

  task automatic send(input logic [31:0] un, input bit push,
                      input int d, input int dr, input int s);
    exp_t e;
    if (push) begin
      e.duty = d;
      e.dir  = dr;
      e.sat  = s;
      sb.push_back(e);
    end
    i_un    = un;
    i_valid = 1'b1;
    @(negedge clk);
    i_valid = 1'b0;
    i_un    = 32'h0;
  endtask

  task automatic wait_upd(input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 2100; i++) begin
      if (upd === 1'b1) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!seen) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_timeout: got no upd within 2100 cycles expected one", name);
    end
  endtask

  task automatic wait_cnt(input int k);
    for (int i = 0; i < 2100; i++) begin
      if (m_cnt == k && !m_idle) break;
      @(negedge clk);
    end
  endtask

  // Starts on a cnt = 0 cycle and samples one full period.
  task automatic check_period(input string name, input int exp);
    int   hi  = 0;
    int   bad = 0;
    logic want;
    for (int i = 0; i < 1000; i++) begin
      want = (i < exp);
      if (pwm === 1'b1) hi++;
      if (pwm !== want) bad++;
      @(negedge clk);
    end
    chk({name, "_high"}, hi, exp);
    chk({name, "_shape"}, bad, 0);
  endtask

  initial begin
    int lows;
    rst     = 1'b1;
    i_en    = 1'b0;
    i_valid = 1'b0;
    i_clr   = 1'b0;
    i_un    = 32'h0;

    // 1. reset with i_valid pulsing
    for (int i = 0; i < 5; i++) begin
      i_valid = i[0];
      i_un    = 32'h7FFF_FFFF;
      @(negedge clk);
      chk("rst_outputs", int'({pwm, dir, sat, upd, ovr, duty}), 0);
    end
    i_valid = 1'b0;
    i_un    = 32'h0;
    rst     = 1'b0;
    i_en    = 1'b1;
    @(negedge clk);
    check_period("rst_first_period", 0);
    chk("rst_duty_hold", int'(duty), 0);

    // 2. positive sample
    send(32'h0000_6400, 1'b1, 100, 0, 0);
    wait_upd("t2");
    check_period("t2_p1", 100);
    check_period("t2_p2", 100);

    // 3. negative samples
    send(32'hFFFF_9C00, 1'b1, 100, 1, 0);
    wait_upd("t3a");
    chk("t3_dir", int'(dir), 1);
    send(32'hFFFF_FFFF, 1'b1, 1, 1, 0);
    wait_upd("t3b");
    check_period("t3_duty1", 1);

    // 4. saturation
    send(32'h7FFF_FFFF, 1'b1, 1000, 0, 1);
    wait_upd("t4a");
    check_period("t4_full", 1000);
    send(32'h8000_0000, 1'b1, 1000, 1, 1);
    wait_upd("t4b");
    chk("t4_sat_neg", int'(sat), 1);

    // 5. overwrite, clear, bypass
    wait_cnt(10);
    send(32'h0000_1400, 1'b0, 0, 0, 0);
    wait_cnt(500);
    send(32'h0000_2800, 1'b1, 40, 0, 0);
    chk("t5_ovr_set", int'(ovr), 1);
    wait_upd("t5a");
    chk("t5_duty40", int'(duty), 40);
    i_clr = 1'b1;
    @(negedge clk);
    i_clr = 1'b0;
    chk("t5_ovr_clr", int'(ovr), 0);
    wait_cnt(999);
    send(32'h0000_3C00, 1'b1, 60, 0, 0);
    chk("t5_bypass_upd", int'(upd), 1);
    chk("t5_bypass_duty", int'(duty), 60);
    // bypass on the boundary beats a waiting pending sample, no overwrite
    wait_cnt(700);
    send(32'h0000_0A00, 1'b0, 0, 0, 0);
    wait_cnt(999);
    send(32'h0000_1E00, 1'b1, 30, 0, 0);
    chk("t5_bypass_pend_upd", int'(upd), 1);
    chk("t5_bypass_pend_duty", int'(duty), 30);
    chk("t5_boundary_no_ovr", int'(ovr), 0);

    // 6. enable drop, re-enable, mid-pulse reset
    send(32'h0001_F400, 1'b1, 500, 0, 0);
    wait_upd("t6a");
    wait_cnt(300);
    i_en = 1'b0;
    @(negedge clk);
    lows = 0;
    for (int i = 0; i < 20; i++) begin
      if (pwm === 1'b0) lows++;
      @(negedge clk);
    end
    chk("t6_disabled_low", lows, 20);
    i_en = 1'b1;
    @(negedge clk);
    check_period("t6_reenable", 500);
    wait_cnt(150);
    send(32'h0000_6400, 1'b0, 0, 0, 0);
    wait_cnt(200);
    chk("t6_pre_rst_pwm", int'(pwm), 1);
    rst = 1'b1;
    @(negedge clk);
    chk("t6_rst_pwm", int'(pwm), 0);
    chk("t6_rst_duty", int'(duty), 0);
    chk("t6_rst_flags", int'({dir, sat, upd, ovr}), 0);
    rst = 1'b0;
    @(negedge clk);
    check_period("t6_after_rst", 0);
    chk("t6_no_stale_pend", int'(duty), 0);

    @(negedge clk);
    chk("sb_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pid_un_pwm.md
# pid_un_pwm

Output stage placed directly downstream of the PID block. Consumes the signed 32-bit control word `o_un` and its `valid` strobe, scales it by an arithmetic right shift, and saturates it to the PWM period. Drives a glitch-free, period-synchronous PWM output plus a direction bit for an H-bridge. Duty changes take effect only at PWM period boundaries, so a pulse is never truncated or stretched mid-period.

## Interface

Parameters:
- `PERIOD`, default 1000: PWM period in clk cycles; also the maximum duty value.
- `CW`, default 10: counter and duty width; must satisfy 2^CW > PERIOD.
- `SHIFT`, default 8: arithmetic right shift applied to `i_un`, giving duty in counter ticks.

Ports:
- `clk` in 1: single system clock; all logic is rising-edge.
- `rst` in 1: synchronous, active-high reset.
- `i_un` in 32: signed control word, connected to PID `o_un`.
- `i_valid` in 1: one-cycle strobe; `i_un` is valid this cycle. Connected to PID `valid`.
- `i_en` in 1: run enable. When low, the counter is held at 0 and `pwm` is forced to 0.
- `i_clr` in 1: clears the `ovr` sticky flag.
- `pwm` out 1: registered PWM output.
- `dir` out 1: registered sign of the active duty; 1 means negative `i_un`.
- `duty` out CW: active duty magnitude, range 0..PERIOD.
- `sat` out 1: active duty was clipped to PERIOD.
- `upd` out 1: one-cycle pulse when a new duty becomes active.
- `ovr` out 1: sticky flag; a pending sample was overwritten before it was applied.

## Operation

- **Conversion.** Computed on each `i_valid`:
  - `s = i_un >>> SHIFT` (signed, 32-bit).
  - `neg = s[31]`.
  - `mag = neg ? -s : s`, computed in 33 bits so that -2^31 is handled.
  - If `mag > PERIOD`, then duty = PERIOD with sat = 1; otherwise duty = `mag[CW-1:0]` with sat = 0.
  - Negative values that shift to -1 (e.g. `i_un` = -1) give mag = 1.
- **Pending register.** On `i_valid`, the converted {duty, neg, sat} is stored in a pending slot and `pend` is set to 1. A newer sample overwrites the slot (latest wins).
  - `ovr` is set if `i_valid` arrives while `pend` = 1 and that cycle is not the boundary cycle.
- **Counter.**
  - When `i_en` = 1: `cnt` runs 0..PERIOD-1 and wraps to 0.
  - When `i_en` = 0: `cnt` is held at 0 and `pwm` is 0. Pending capture continues, but no boundary occurs.
- **Boundary.** The boundary cycle is `cnt` == PERIOD-1 with `i_en` = 1. At its closing edge:
  - If `i_valid` is high that cycle, the freshly converted value is applied directly. This bypass beats the pending slot.
  - Otherwise, if `pend` = 1, the pending value is applied.
  - Applying a value loads `duty`, `dir` and `sat`, clears `pend`, and sets `upd` = 1 for the next cycle.
  - If nothing is new, the active values persist and `upd` stays 0.
- **PWM.** `pwm` is registered. In any cycle where `cnt` == k, `pwm` = (k < `duty`) && `i_en`.
  - duty = 0 gives constant low.
  - duty = PERIOD gives constant high.
- **`i_clr`.** Clears `ovr` at the next edge. If `i_clr` and an overwrite occur in the same cycle, the set wins.
- **States.** IDLE (`i_en` = 0) and RUN. Any edge with `i_en` = 0 returns to IDLE with `cnt` = 0. The first RUN cycle has `cnt` = 0.

## Timing

- **Reset values.** At the edge where `rst` = 1: `pwm`=0, `dir`=0, `duty`=0, `sat`=0, `upd`=0, `ovr`=0, `cnt`=0, `pend`=0, pending slot = 0.
  - Reset mid-period takes effect at that edge. No pending value survives.
- **`i_valid` to active duty.** Worst-case latency is PERIOD cycles, with no loss of the latest sample.
  - Valid seen on the boundary cycle: the new duty is visible in the very next cycle (`cnt` = 0).
- **`upd` pulse.** Exactly one cycle, coincident with the first `cnt` = 0 cycle that uses the new duty.
- **Handshake.** `i_valid` needs no acknowledge and `i_un` need not be held after the strobe cycle.
- **Sustained input.** Back-to-back `i_valid` every cycle is legal. Only the value present at the boundary is applied; `ovr` is set.

## Test plan

1. **Reset.** Hold `rst` for 5 cycles with `i_valid` pulsing -> all outputs 0. After release with `i_en`=1, `pwm` stays low until the first boundary.
2. **Positive sample.** `i_un`=0x00006400, then wait for the boundary -> `duty`=100, `dir`=0, `sat`=0, one `upd` pulse. `pwm` is high for `cnt` 0..99 and low for 100..999, repeating every 1000 cycles.
3. **Negative sample.** `i_un`=0xFFFF9C00 -> `duty`=100, `dir`=1. `i_un`=0xFFFFFFFF -> `duty`=1, `dir`=1.
4. **Saturation.** `i_un`=0x7FFFFFFF -> `duty`=1000, `sat`=1, `pwm` constantly high. `i_un`=0x80000000 -> `duty`=1000, `dir`=1, `sat`=1.
5. **Overwrite and bypass.**
   - Send 0x1400 at `cnt`=10, then 0x2800 at `cnt`=500 -> `duty`=40 at the boundary, `ovr`=1.
   - Pulse `i_clr` -> `ovr`=0.
   - Send 0x3C00 exactly at `cnt`=999 -> `duty`=60 in the next cycle.
6. **Enable and mid-run reset.**
   - Drop `i_en` at `cnt`=300 with duty 500 active -> `pwm`=0 and `cnt`=0 from the next cycle.
   - Raise `i_en` again -> a full 500-cycle pulse.
   - Assert `rst` mid-pulse -> `pwm`=0 and `duty`=0 at that edge.
